i2s_frame_ctrl: RTL and testbench

//  Frame sequencer between i2s_tx/i2s_rx and the audio DSP. Generates lrclk from sclk, captures

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_frame_counter.sv | 40 ++++
 rtl/i2s_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S frame sequencer.
package i2s_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int BITS_PER_CH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_frame_counter.sv
// Bit position within the stereo frame; derives lrclk, frame_start and frame_end.
module i2s_frame_counter #(
  parameter int BITS_PER_CH = 16
) (
  input  logic sclk,
  input  logic rst,
  input  logic run,
  output logic lrclk,
  output logic frame_start,
  output logic frame_end
);

  localparam int FRAME = 2 * BITS_PER_CH;
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;

  always_comb begin
    frame_end   = run && (bit_cnt_q == CNT_W'(FRAME - 1));
    frame_start = run && (bit_cnt_q == '0);
    bit_cnt_d   = '0;
    if (run && !frame_end) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    // Registered so lrclk tracks the count it is stored alongside.
    lrclk_d = (bit_cnt_d >= CNT_W'(BITS_PER_CH));
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Frame sequencer between the I2S transceivers and the DSP.
// Optional: define I2S_STATUS_CNT_EN for saturating overrun/underrun event counters.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              enable,
  output logic              lrclk,
  output logic              frame_start,
  input  logic [DATA_W-1:0] rx_left_in,
  input  logic [DATA_W-1:0] rx_right_in,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_left_in,
  input  logic [DATA_W-1:0] tx_right_in,
  output logic [DATA_W-1:0] tx_left,
  output logic [DATA_W-1:0] tx_right,
  input  logic              clr_status,
  output logic              overrun,
  output logic              underrun
`ifdef I2S_STATUS_CNT_EN
  ,
  output logic [7:0]        ovr_cnt,
  output logic [7:0]        udr_cnt
`endif
);

  state_e            state_q, state_d;
  logic              frame_end;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_left_q, hold_left_d, hold_right_q, hold_right_d;
  logic [DATA_W-1:0] tx_left_q, tx_left_d, tx_right_q, tx_right_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
  logic              ovr_q, ovr_d, udr_q, udr_d;
  logic              ovr_evt, udr_evt;

  i2s_frame_counter #(.BITS_PER_CH(BITS_PER_CH)) u_cnt (
    .sclk        (sclk),
    .rst         (rst),
    .run         (state_q != IDLE),
    .lrclk       (lrclk),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    tx_left_d    = tx_left_q;
    tx_right_d   = tx_right_q;
    rx_valid_d   = rx_valid_q;
    rx_left_d    = rx_left_q;
    rx_right_d   = rx_right_q;
    ovr_evt      = 1'b0;
    udr_evt      = 1'b0;

    case (state_q)
      IDLE:    if (enable) state_d = SYNC;
      SYNC:    if (frame_end) state_d = enable ? RUN : IDLE;
      RUN:     if (frame_end && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    // The SYNC frame is partial, so only RUN frames are captured.
    if (frame_end && state_q == RUN) begin
      rx_left_d  = rx_left_in;
      rx_right_d = rx_right_in;
      rx_valid_d = 1'b1;
      ovr_evt    = rx_valid_q && !rx_ready;
    end

    if (tx_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_left_d  = tx_left_in;
      hold_right_d = tx_right_in;
    end
    if (frame_end) begin
      if (state_d == IDLE) begin
        tx_left_d  = '0;
        tx_right_d = '0;
      end else if (hold_valid_q) begin
        tx_left_d    = hold_left_q;
        tx_right_d   = hold_right_q;
        hold_valid_d = 1'b0;
      end else if (state_q == RUN) begin
        udr_evt = 1'b1;
      end
    end

    ovr_d = ovr_evt ? 1'b1 : (clr_status ? 1'b0 : ovr_q);
    udr_d = udr_evt ? 1'b1 : (clr_status ? 1'b0 : udr_q);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      tx_left_q    <= '0;
      tx_right_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_left_q    <= '0;
      rx_right_q   <= '0;
      ovr_q        <= 1'b0;
      udr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      tx_left_q    <= tx_left_d;
      tx_right_q   <= tx_right_d;
      rx_valid_q   <= rx_valid_d;
      rx_left_q    <= rx_left_d;
      rx_right_q   <= rx_right_d;
      ovr_q        <= ovr_d;
      udr_q        <= udr_d;
    end
  end

`ifdef I2S_STATUS_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d, udr_cnt_q, udr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    udr_cnt_d = udr_cnt_q;
    if (clr_status) begin
      ovr_cnt_d = ovr_evt ? 8'd1 : 8'd0;
      udr_cnt_d = udr_evt ? 8'd1 : 8'd0;
    end else begin
      if (ovr_evt) ovr_cnt_d = sat_inc8(ovr_cnt_q);
      if (udr_evt) udr_cnt_d = sat_inc8(udr_cnt_q);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      ovr_cnt_q <= 8'd0;
      udr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      udr_cnt_q <= udr_cnt_d;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
  assign udr_cnt = udr_cnt_q;
`endif

  assign tx_ready = !hold_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_left  = rx_left_q;
  assign rx_right = rx_right_q;
  assign tx_left  = tx_left_q;
  assign tx_right = tx_right_q;
  assign overrun  = ovr_q;
  assign underrun = udr_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl; rx frames are scoreboarded, the rest checked inline.
module tb_i2s_frame_ctrl;

  localparam int HALF  = 16;
  localparam int FRAME = 2 * HALF;
  localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2;

  logic        sclk, rst, enable;
  logic        lrclk, frame_start;
  logic [15:0] rx_left_in, rx_right_in, rx_left, rx_right;
  logic        rx_valid, rx_ready;
  logic        tx_valid, tx_ready;
  logic [15:0] tx_left_in, tx_right_in, tx_left, tx_right;
  logic        clr_status, overrun, underrun;
`ifdef I2S_STATUS_CNT_EN
  logic [7:0]  ovr_cnt, udr_cnt;
`endif

  i2s_frame_ctrl #(.DATA_W(16), .BITS_PER_CH(HALF)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .enable      (enable),
    .lrclk       (lrclk),
    .frame_start (frame_start),
    .rx_left_in  (rx_left_in),
    .rx_right_in (rx_right_in),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_left     (rx_left),
    .rx_right    (rx_right),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_left_in  (tx_left_in),
    .tx_right_in (tx_right_in),
    .tx_left     (tx_left),
    .tx_right    (tx_right),
    .clr_status  (clr_status),
    .overrun     (overrun),
    .underrun    (underrun)
`ifdef I2S_STATUS_CNT_EN
    ,
    .ovr_cnt     (ovr_cnt),
    .udr_cnt     (udr_cnt)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } rx_t;

  rx_t rx_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  mode = M_IDLE;
  int  bc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advances one sclk edge: predicts frame position, logs rx captures, then checks lrclk/frame_start.
  task automatic tick();
    rx_t e;
    if (rst) begin
      mode = M_IDLE;
      bc   = 0;
      rx_q.delete();
    end else if (mode == M_IDLE) begin
      if (enable) begin
        mode = M_SYNC;
        bc   = 0;
      end
    end else if (bc == FRAME - 1) begin
      if (mode == M_RUN) begin
        if (rx_q.size() != 0 && !rx_ready) void'(rx_q.pop_front());
        e.l = rx_left_in;
        e.r = rx_right_in;
        rx_q.push_back(e);
      end
      mode = enable ? M_RUN : M_IDLE;
      bc   = 0;
    end else begin
      bc++;
    end
    @(negedge sclk);
    if (mode == M_IDLE) begin
      chk("lrclk_idle", lrclk, 0);
      chk("fstart_idle", frame_start, 0);
    end else begin
      chk("lrclk", lrclk, bc >= HALF);
      chk("fstart", frame_start, bc == 0);
    end
  endtask

  task automatic goto_bc(input int t);
    for (int i = 0; i < FRAME && bc != t; i++) tick();
  endtask

  task automatic tx_push(input logic [15:0] l, input logic [15:0] r);
    chk("tx_ready_pre", tx_ready, 1);
    tx_valid    = 1'b1;
    tx_left_in  = l;
    tx_right_in = r;
    tick();
    tx_valid = 1'b0;
    chk("tx_ready_post", tx_ready, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_left", rx_left, 0);
    chk("rst_rx_right", rx_right, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_left", tx_left, 0);
    chk("rst_tx_right", tx_right, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
  endtask

  // rx scoreboard: each handshake pops the oldest expected frame
  initial begin
    rx_t e;
    forever begin
      @(negedge sclk);
      #1;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected", rx_valid, 0);
        end else begin
          e = rx_q.pop_front();
          chk("rx_left", rx_left, e.l);
          chk("rx_right", rx_right, e.r);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; clr_status = 1'b0;
    rx_left_in = '0; rx_right_in = '0; tx_left_in = '0; tx_right_in = '0;
    repeat (3) tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();

    // SYNC frame: lrclk timing, nothing captured, no underrun
    enable = 1'b1;
    tick();
    chk("sync_rx_valid", rx_valid, 0);
    for (int i = 1; i < FRAME; i++) begin
      tick();
      chk("sync_rx_valid", rx_valid, 0);
      chk("sync_underrun", underrun, 0);
    end
    tick();
    chk("sync_end_underrun", underrun, 0);

    // RUN frame 1: tx push mid-frame, rx capture with ready
    rx_ready = 1'b1;
    goto_bc(5);
    tx_push(16'h0F0F, 16'hF0F0);
    chk("tx_not_early", tx_left, 0);
    goto_bc(FRAME - 1);
    chk("tx_ready_until_end", tx_ready, 0);
    rx_left_in = 16'h1234; rx_right_in = 16'hABCD;
    tick();
    chk("rx_valid_f1", rx_valid, 1);
    chk("overrun_f1", overrun, 0);
    chk("tx_left_f1", tx_left, 16'h0F0F);
    chk("tx_right_f1", tx_right, 16'hF0F0);
    chk("tx_ready_drained", tx_ready, 1);
    chk("underrun_f1", underrun, 0);
    rx_left_in = 16'hDEAD; rx_right_in = 16'hBEEF;
    tick();
    chk("rx_valid_pulse", rx_valid, 0);

    // two frames without rx_ready -> overrun, second frame kept
    rx_ready = 1'b0;
    goto_bc(3);
    tx_push(16'h1111, 16'h2222);
    goto_bc(FRAME - 1);
    rx_left_in = 16'hA1A1; rx_right_in = 16'hA2A2;
    tick();
    chk("rx_valid_a", rx_valid, 1);
    chk("overrun_a", overrun, 0);
    chk("rx_left_a", rx_left, 16'hA1A1);
    chk("tx_left_a", tx_left, 16'h1111);
    goto_bc(3);
    tx_push(16'h3333, 16'h4444);
    goto_bc(FRAME - 1);
    rx_left_in = 16'hB1B1; rx_right_in = 16'hB2B2;
    tick();
    chk("overrun_set", overrun, 1);
    chk("rx_left_b", rx_left, 16'hB1B1);
    chk("rx_right_b", rx_right, 16'hB2B2);
    chk("tx_left_b", tx_left, 16'h3333);
    chk("underrun_b", underrun, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("overrun_clr", overrun, 0);
    rx_ready = 1'b1;
    tick();
    chk("rx_valid_consumed", rx_valid, 0);

    // frame without tx push -> underrun, tx outputs held
    goto_bc(FRAME - 1);
    rx_ready = 1'b0;
    rx_left_in = 16'hC1C1; rx_right_in = 16'hC2C2;
    tick();
    chk("underrun_set", underrun, 1);
    chk("tx_left_held", tx_left, 16'h3333);
    chk("tx_right_held", tx_right, 16'h4444);
    chk("rx_valid_c", rx_valid, 1);

    // consume coincident with capture: new frame wins, no overrun
    goto_bc(FRAME - 1);
    rx_ready = 1'b1;
    rx_left_in = 16'hD1D1; rx_right_in = 16'hD2D2;
    tick();
    chk("rx_valid_coinc", rx_valid, 1);
    chk("overrun_coinc", overrun, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("underrun_clr", underrun, 0);
    chk("rx_valid_d_taken", rx_valid, 0);
    goto_bc(2);
    tx_push(16'h5555, 16'h6666);
    goto_bc(FRAME - 1);
    tick();
    chk("tx_left_e", tx_left, 16'h5555);
    chk("underrun_e", underrun, 0);

    // clear coincident with an underrun event: set wins
    goto_bc(FRAME - 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("underrun_set_wins", underrun, 1);

    // enable dropped mid-frame: frame completes, then IDLE with tx cleared
    goto_bc(2);
    tx_push(16'h7777, 16'h8888);
    goto_bc(5);
    enable = 1'b0;
    goto_bc(FRAME - 1);
    chk("tx_left_before_idle", tx_left, 16'h5555);
    tick();
    chk("idle_tx_left", tx_left, 0);
    chk("idle_tx_right", tx_right, 0);
    repeat (3) tick();

    // re-enable: SYNC drains the pending hold; then reset mid-frame
    enable = 1'b1;
    tick();
    goto_bc(FRAME - 1);
    tick();
    chk("sync_drain_left", tx_left, 16'h7777);
    chk("sync_drain_right", tx_right, 16'h8888);
    rx_ready = 1'b0;
    goto_bc(3);
    tx_push(16'h9999, 16'hAAAA);
    goto_bc(FRAME - 1);
    rx_left_in = 16'hE1E1; rx_right_in = 16'hE2E2;
    tick();
    chk("rx_valid_e", rx_valid, 1);
    goto_bc(20);
    rst = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset_vals();
    tick();

`ifdef I2S_STATUS_CNT_EN
    chk("rst_udr_cnt", udr_cnt, 0);
    rx_ready = 1'b1;
    enable = 1'b1;
    tick();
    goto_bc(FRAME - 1);
    tick();
    chk("udr_cnt_start", udr_cnt, 0);
    for (int f = 0; f < 300; f++) begin
      goto_bc(FRAME - 1);
      tick();
      if (f == 9) chk("udr_cnt_10", udr_cnt, 10);
    end
    chk("udr_cnt_sat", udr_cnt, 255);
    chk("ovr_cnt_zero", ovr_cnt, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("udr_cnt_clr", udr_cnt, 0);
    enable = 1'b0;
    goto_bc(FRAME - 1);
    tick();
    tick();
`endif

    chk("sb_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
